// File: rtl/change_dispenser.sv
// Greedy coin dispenser: pays out a change amount one coin per cycle, taking the
// largest denomination that still fits and is in stock, and flags inexact change.
module change_dispenser #(
  parameter int D0 = 1,
  parameter int D1 = 5,
  parameter int D2 = 10,
  parameter int D3 = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] amt,
  input  logic       load,
  input  logic [1:0] load_sel,
  input  logic [7:0] load_cnt,
  output logic [1:0] coin,
  output logic       coin_vld,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rem,
  output logic [7:0] inv_q
);

  typedef enum logic [1:0] {IDLE, DISP, FIN} state_t;

  localparam int DENOM [4] = '{D0, D1, D2, D3};

  state_t     state;
  logic [7:0] inv [4];

  logic       pick_ok;
  logic [1:0] pick;
  logic [7:0] pick_val;

  // Ascending scan, last hit wins: denominations increase with code, so the
  // surviving pick is the largest coin that fits the remainder and is stocked.
  always_comb begin
    pick_ok  = 1'b0;
    pick     = 2'd0;
    pick_val = 8'd0;
    for (int k = 0; k < 4; k++) begin
      if (inv[k] != 8'd0 && DENOM[k] <= int'(rem)) begin
        pick_ok  = 1'b1;
        pick     = 2'(k);
        pick_val = 8'(DENOM[k]);
      end
    end
  end

  assign inv_q = inv[load_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      for (int k = 0; k < 4; k++) inv[k] <= 8'd0;
      rem      <= 8'd0;
      coin     <= 2'd0;
      coin_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          coin_vld <= 1'b0;
          done     <= 1'b0;
          if (load) inv[load_sel] <= load_cnt;
          if (start) begin
            rem   <= amt;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= DISP;
          end
        end
        DISP: begin
          if (pick_ok) begin
            coin      <= pick;
            coin_vld  <= 1'b1;
            rem       <= rem - pick_val;
            inv[pick] <= inv[pick] - 8'd1;
          end else begin
            // Nothing fits: whatever remains is the shortfall reported to the host.
            coin_vld <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            err      <= (rem != 8'd0);
            state    <= FIN;
          end
        end
        FIN: begin
          coin_vld <= 1'b0;
          done     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized and directed checks of change_dispenser against a greedy
// change-making model held as plain integer arrays and queues.
module tb_change_dispenser;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, load = 1'b0;
  logic [7:0] amt = 8'd0, load_cnt = 8'd0;
  logic [1:0] load_sel = 2'd0;
  logic [1:0] coin;
  logic       coin_vld, busy, done, err;
  logic [7:0] rem, inv_q;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk(clk), .rst(rst), .start(start), .amt(amt), .load(load),
    .load_sel(load_sel), .load_cnt(load_cnt), .coin(coin), .coin_vld(coin_vld),
    .busy(busy), .done(done), .err(err), .rem(rem), .inv_q(inv_q)
  );

  int tests = 0, fails = 0;
  int dv [4] = '{1, 5, 10, 50};
  int mi [4] = '{0, 0, 0, 0};
  int exp_coins[$], obs_coins[$];
  int exp_rem, lat;
  bit exp_err, busy_all, busy_at_done, vld_at_done, done_after;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic load_inv(input int sel, input int cnt);
    load = 1'b1; load_sel = 2'(sel); load_cnt = 8'(cnt);
    tick();
    load = 1'b0;
    mi[sel] = cnt;
  endtask

  // Reference: repeatedly take the largest stocked coin not exceeding what is owed.
  task automatic model_run(input int a);
    int r;
    bit found;
    r = a;
    exp_coins.delete();
    do begin
      found = 1'b0;
      for (int k = 3; k >= 0; k--) begin
        if (!found && mi[k] > 0 && dv[k] <= r) begin
          exp_coins.push_back(k);
          r -= dv[k];
          mi[k]--;
          found = 1'b1;
        end
      end
    end while (found);
    exp_rem = r;
    exp_err = (r != 0);
  endtask

  // Drives one transaction and records what the DUT did; no judgement here.
  task automatic collect(input int a, input bit ld, input int ld_sel, input int ld_cnt);
    start = 1'b1; amt = 8'(a);
    load = ld; load_sel = 2'(ld_sel); load_cnt = 8'(ld_cnt);
    tick();
    start = 1'b0; load = 1'b0;
    obs_coins.delete();
    lat = -1; busy_all = 1'b1; busy_at_done = 1'b0; vld_at_done = 1'b0; done_after = 1'b0;
    for (int j = 1; j <= 300; j++) begin
      tick();
      if (done) begin
        lat = j; busy_at_done = busy; vld_at_done = coin_vld;
        break;
      end
      busy_all &= busy;
      if (coin_vld) obs_coins.push_back(int'(coin));
    end
    if (lat != -1) begin
      tick();
      done_after = done;
    end
  endtask

  task automatic test_reset;
    #2;
    tests++; if ({coin, coin_vld, busy, done, err} !== 6'd0) begin fails++; $display("FAIL reset_ctrl got %b want 000000", {coin, coin_vld, busy, done, err}); end
    tests++; if (rem !== 8'd0) begin fails++; $display("FAIL reset_rem got %0d want 0", rem); end
    for (int k = 0; k < 4; k++) begin
      load_sel = 2'(k); #1;
      tests++; if (inv_q !== 8'd0) begin fails++; $display("FAIL reset_inv%0d got %0d want 0", k, inv_q); end
    end
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_directed;
    int t_inv [5][4] = '{'{10,10,10,10}, '{0,0,10,0}, '{2,0,0,0}, '{3,3,3,3}, '{0,0,0,0}};
    int t_amt [5] = '{67, 60, 7, 0, 50};
    bit t_co  [5] = '{0, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) load_inv(k, t_inv[i][k]);
      if (t_co[i]) mi[3] = 1;
      model_run(t_amt[i]);
      collect(t_amt[i], t_co[i], 3, 1);
      tests++; if (lat !== exp_coins.size() + 1) begin fails++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, exp_coins.size() + 1); end
      tests++; if (obs_coins.size() !== exp_coins.size()) begin fails++; $display("FAIL dir%0d_ncoins got %0d want %0d", i, obs_coins.size(), exp_coins.size()); end
      else for (int c = 0; c < exp_coins.size(); c++) begin
        tests++; if (obs_coins[c] !== exp_coins[c]) begin fails++; $display("FAIL dir%0d_coin%0d got %0d want %0d", i, c, obs_coins[c], exp_coins[c]); end
      end
      tests++; if (err !== exp_err || rem !== 8'(exp_rem)) begin fails++; $display("FAIL dir%0d_result got err=%0b rem=%0d want err=%0b rem=%0d", i, err, rem, exp_err, exp_rem); end
      tests++; if (!busy_all || busy_at_done || vld_at_done || done_after) begin fails++; $display("FAIL dir%0d_handshake got busy_all=%0b busy@done=%0b vld@done=%0b done_after=%0b want 1000", i, busy_all, busy_at_done, vld_at_done, done_after); end
      if (exp_coins.size() > 0) begin
        tests++; if (coin !== 2'(exp_coins[$])) begin fails++; $display("FAIL dir%0d_coin_hold got %0d want %0d", i, coin, exp_coins[$]); end
      end
      for (int k = 0; k < 4; k++) begin
        load_sel = 2'(k); #1;
        tests++; if (inv_q !== 8'(mi[k])) begin fails++; $display("FAIL dir%0d_inv%0d got %0d want %0d", i, k, inv_q, mi[k]); end
      end
    end
  endtask

  task automatic test_busy_ignore;
    int n;
    load_inv(0, 20); load_inv(1, 0); load_inv(2, 0); load_inv(3, 1);
    model_run(15);
    start = 1'b1; amt = 8'd15;
    tick();
    start = 1'b1; amt = 8'd200; load = 1'b1; load_sel = 2'd3; load_cnt = 8'd99;
    n = 0; lat = -1;
    for (int j = 1; j <= 100; j++) begin
      tick();
      if (done) begin lat = j; break; end
      if (coin_vld) n++;
    end
    start = 1'b0; load = 1'b0;
    tick(); tick();
    tests++; if (lat !== 16 || n !== 15) begin fails++; $display("FAIL busy_ignore_txn got lat=%0d coins=%0d want lat=16 coins=15", lat, n); end
    tests++; if (rem !== 8'(exp_rem) || err !== exp_err || busy !== 1'b0) begin fails++; $display("FAIL busy_ignore_rem got rem=%0d err=%0b busy=%0b want 0 0 0", rem, err, busy); end
    load_sel = 2'd3; #1;
    tests++; if (inv_q !== 8'(mi[3])) begin fails++; $display("FAIL busy_ignore_inv3 got %0d want %0d", inv_q, mi[3]); end
  endtask

  task automatic test_reset_mid_disp;
    load_inv(0, 200);
    start = 1'b1; amt = 8'd100;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    tests++; if ({coin, coin_vld, busy, done, err} !== 6'd0 || rem !== 8'd0) begin fails++; $display("FAIL rst_mid_outputs got ctrl=%b rem=%0d want 000000 0", {coin, coin_vld, busy, done, err}, rem); end
    load_sel = 2'd0; #1;
    tests++; if (inv_q !== 8'd0) begin fails++; $display("FAIL rst_mid_inv0 got %0d want 0", inv_q); end
    for (int j = 0; j < 3; j++) begin
      tick();
      tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_mid_hold got done=%0b busy=%0b want 0 0", done, busy); end
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) mi[k] = 0;
    tick();
  endtask

  task automatic test_random;
    int a, co_cnt;
    bit co;
    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 2) != 0) load_inv(k, $urandom_range(0, 12));
      a = $urandom_range(0, 255);
      co = ($urandom_range(0, 3) == 0);
      co_cnt = $urandom_range(0, 5);
      if (co) mi[3] = co_cnt;
      model_run(a);
      collect(a, co, 3, co_cnt);
      tests++; if (lat !== exp_coins.size() + 1) begin fails++; $display("FAIL rnd%0d_latency amt=%0d got %0d want %0d", i, a, lat, exp_coins.size() + 1); end
      tests++; if (obs_coins !== exp_coins) begin fails++; $display("FAIL rnd%0d_coins amt=%0d got %p want %p", i, a, obs_coins, exp_coins); end
      tests++; if (err !== exp_err || rem !== 8'(exp_rem)) begin fails++; $display("FAIL rnd%0d_result got err=%0b rem=%0d want err=%0b rem=%0d", i, err, rem, exp_err, exp_rem); end
      tests++; if (!busy_all || busy_at_done || vld_at_done || done_after) begin fails++; $display("FAIL rnd%0d_handshake got %0b%0b%0b%0b want 1000", i, busy_all, busy_at_done, vld_at_done, done_after); end
      for (int k = 0; k < 4; k++) begin
        load_sel = 2'(k); #1;
        tests++; if (inv_q !== 8'(mi[k])) begin fails++; $display("FAIL rnd%0d_inv%0d got %0d want %0d", i, k, inv_q, mi[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid_disp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL define parameters (name, default, meaning):
- D0, 1, value of denomination code 0
- D1, 5, value of denomination code 1
- D2, 10, value of denomination code 2
- D3, 50, value of denomination code 3
- Constraint: D3>D2>D1>D0>=1.
REQ-002 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request to dispense amt; sampled only while idle
- amt  in  8  change value in units, taken from the vending stage MO output
- load  in  1  inventory write strobe
- load_sel  in  2  denomination code for load and for inv_q readback
- load_cnt  in  8  coin count written on load
- coin  out  2  denomination code of the coin dispensed this cycle
- coin_vld  out  1  one coin of code coin is dispensed this cycle
- busy  out  1  dispense in progress
- done  out  1  one-cycle completion pulse
- err  out  1  exact change impossible; valid with done, held until next start
- rem  out  8  undispensed remainder
- inv_q  out  8  current inventory of denomination load_sel (combinational read)

Function
REQ-003 SHALL implement a three-state FSM: IDLE, DISP, FIN.
REQ-004 SHALL keep four 8-bit inventory counters inv[0..3], one per denomination code.
REQ-005 In IDLE with load=1, SHALL write inv[load_sel]=load_cnt at the edge; load SHALL be ignored in DISP and FIN.
REQ-006 In IDLE with start=1, SHALL latch rem=amt, clear err, set busy=1, and go to DISP at the same edge.
REQ-007 When load and start are both high in IDLE, SHALL apply both; dispensing SHALL use the updated inventory.
REQ-008 start SHALL be ignored while busy=1 or in FIN.
REQ-009 At each DISP edge with rem>0, SHALL select the highest code k with Dk<=rem and inv[k]>0, then:
- register coin=k and coin_vld=1
- rem=rem-Dk
- inv[k]=inv[k]-1
REQ-010 At a DISP edge with no eligible code, SHALL go to FIN with coin_vld=0 and busy=0:
- rem=0 sets err=0
- rem>0 sets err=1, and rem holds the undispensed value
REQ-011 In FIN, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; coin_vld SHALL be 0.
REQ-012 At most one coin SHALL be dispensed per cycle; coin_vld SHALL be 0 outside cycles following a dispensing edge.
REQ-013 Latency SHALL be N+1 DISP edges for N coins:
- done is high in the cycle after the (N+1)th edge following start
- amt=0 gives done in the second cycle after start, with no coin_vld
REQ-014 Inventory arithmetic SHALL never wrap: a counter at 0 is ineligible, and there is no increment path other than load.
REQ-015 Subtractions on rem SHALL be 8-bit; the selection rule guarantees no underflow.
REQ-016 coin SHALL hold its last value when coin_vld=0.

Reset
REQ-017 rst=1 SHALL asynchronously force:
- state=IDLE
- inv[0..3]=0
- rem=0
- coin=0
- coin_vld=0, busy=0, done=0, err=0
REQ-018 Reset during DISP SHALL abort the operation with no done pulse; the dispensed coins are not restored.
REQ-019 After reset release, the first edge SHALL honor start/load per REQ-005..REQ-007.

Verification
REQ-020 Load inv[0..3]=10, start amt=67 -> coin sequence 3,2,1,0,0 on 5 consecutive cycles, then done=1, err=0, rem=0; inv_q reads 8,9,9,9 for codes 0..3.
REQ-021 Load inv[3]=0, inv[2]=10, start amt=60 -> six consecutive coins of code 2, done=1, err=0, inv[2]=4.
REQ-022 Load only inv[0]=2, start amt=7 -> coins 0,0, then done=1, err=1, rem=5, inv[0]=0.
REQ-023 Start amt=0 -> no coin_vld, done=1 in the second cycle after start, err=0.
REQ-024 Assert start and load (sel=3, cnt=99) while busy -> both ignored; inv[3] and rem are unaffected. Assert rst mid-DISP -> all outputs 0 immediately, inv_q=0, no done.
REQ-025 Load and start in the same IDLE cycle (inv[3]=1, amt=50) -> single coin of code 3, done=1, err=0.
